// File: rtl/udp_payload_packer.sv
// udp_payload_packer: buffers an AXI-Stream byte stream into one packet,
// closes it on TLAST, on reaching MAX_PAYLOAD bytes, or after an idle
// timeout, then replays it with the payload length on TUSER for every beat.
module udp_payload_packer #(
  parameter int MAX_PAYLOAD    = 1024,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  input  logic        S_AXIS_TLAST,
  output logic        S_AXIS_TREADY,
  output logic [7:0]  M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  output logic [11:0] M_AXIS_TUSER,
  input  logic        M_AXIS_TREADY
);

  localparam int          AW       = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [11:0] MAX_LEN  = 12'(MAX_PAYLOAD);
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic {ST_FILL, ST_DRAIN} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_mem [MAX_PAYLOAD];
  logic [11:0] r_wr_cnt;
  logic [11:0] r_rd_cnt;
  logic [11:0] r_len;
  logic [31:0] r_timer;
  logic        r_s_tready;

  // read stage: registered memory output waiting to move into the output regs
  logic [7:0]  r_q_data;
  logic        r_q_valid;
  logic        r_q_last;

  // output register stage
  logic [7:0]  r_m_tdata;
  logic        r_m_tvalid;
  logic        r_m_tlast;
  logic [11:0] r_m_tuser;

  logic        w_in_hs;
  logic [11:0] w_wr_cnt_inc;
  logic        w_close_hs;
  logic        w_timer_active;
  logic        w_timeout;
  logic        w_close;
  logic        w_out_hs;
  logic        w_end;
  logic        w_b_load;
  logic        w_rd_en;

  // TREADY is only ever high in FILL, so this is also the write enable
  assign w_in_hs        = r_s_tready && S_AXIS_TVALID;
  assign w_wr_cnt_inc   = r_wr_cnt + 12'd1;
  assign w_close_hs     = w_in_hs && (S_AXIS_TLAST || (w_wr_cnt_inc == MAX_LEN));
  // an empty buffer never times out
  assign w_timer_active = TMO_EN && (r_state == ST_FILL) && (r_wr_cnt != 12'd0);
  assign w_timeout      = w_timer_active && !w_in_hs && (r_timer == TMO_LAST);
  assign w_close        = w_close_hs || w_timeout;

  assign w_out_hs = r_m_tvalid && M_AXIS_TREADY;
  assign w_end    = w_out_hs && r_m_tlast;
  // read stage moves forward whenever the output register is empty or emptying
  assign w_b_load = r_q_valid && (!r_m_tvalid || M_AXIS_TREADY);
  // issue the next memory read only if the read stage will be free
  assign w_rd_en  = (r_state == ST_DRAIN) && (r_rd_cnt < r_len) && (!r_q_valid || w_b_load);

  assign S_AXIS_TREADY = r_s_tready;
  assign M_AXIS_TDATA  = r_m_tdata;
  assign M_AXIS_TVALID = r_m_tvalid;
  assign M_AXIS_TLAST  = r_m_tlast;
  assign M_AXIS_TUSER  = r_m_tuser;

  // state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state: close a packet in FILL, return after the last beat in DRAIN
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FILL:  if (w_close) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_end)   w_state_next = ST_FILL;
      default:  w_state_next = ST_FILL;
    endcase
  end

  // fill side: write counter, idle timer, latched length and input ready
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_cnt   <= 12'd0;
      r_len      <= 12'd0;
      r_timer    <= 32'd0;
      r_s_tready <= 1'b0;
    end else begin
      r_s_tready <= (w_state_next == ST_FILL);
      if (w_end) begin
        r_wr_cnt <= 12'd0;
        r_timer  <= 32'd0;
      end else if (r_state == ST_FILL) begin
        if (w_in_hs) begin
          r_wr_cnt <= w_wr_cnt_inc;
          r_timer  <= 32'd0;
        end else if (w_timer_active) begin
          r_timer <= r_timer + 32'd1;
        end
        if (w_close_hs) begin
          r_len <= w_wr_cnt_inc;
        end else if (w_timeout) begin
          r_len <= r_wr_cnt;
        end
      end
    end
  end

  // byte buffer with synchronous, enabled read
  always_ff @(posedge CLK) begin
    if (w_in_hs) begin
      r_mem[r_wr_cnt[AW-1:0]] <= S_AXIS_TDATA;
    end
    if (w_rd_en) begin
      r_q_data <= r_mem[r_rd_cnt[AW-1:0]];
    end
  end

  // drain side: read counter, read-stage flags and output register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_cnt   <= 12'd0;
      r_q_valid  <= 1'b0;
      r_q_last   <= 1'b0;
      r_m_tdata  <= 8'd0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 12'd0;
    end else begin
      if (w_end) begin
        r_rd_cnt <= 12'd0;
      end else if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + 12'd1;
      end

      if (w_rd_en) begin
        r_q_valid <= 1'b1;
        r_q_last  <= (r_rd_cnt == (r_len - 12'd1));
      end else if (w_b_load) begin
        r_q_valid <= 1'b0;
      end

      if (w_b_load) begin
        r_m_tdata  <= r_q_data;
        r_m_tlast  <= r_q_last;
        r_m_tuser  <= r_len;
        r_m_tvalid <= 1'b1;
      end else if (w_out_hs) begin
        r_m_tvalid <= 1'b0;
        r_m_tlast  <= 1'b0;
      end
    end
  end

endmodule
